// File: rtl/dff_pc_arb_pkg.sv
// rtl/dff_pc_arb_pkg.sv - op encoding, FSM states and sequence length for dff_pc_arbiter
package dff_pc_arb_pkg;

  // Requester operation codes as presented on the op bus
  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_LOAD  = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Transaction sequence; encodings are consecutive so the walk is a simple increment
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_APPLY  = 3'd2,
    ST_SETTLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Cycles per serviced operation, IDLE included
  localparam int unsigned SEQ_LEN = 5;

  // True in the final state of the sequence
  function automatic logic is_last_state(input state_e s);
    return (int'(s) == int'(SEQ_LEN) - 1);
  endfunction

endpackage

// File: rtl/dff_pc_arbiter_rr_arbiter.sv
// rtl/dff_pc_arbiter_rr_arbiter.sv - round-robin arbiter, pointer advances past the accepted winner
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic          found;

  function automatic int wrap(input int v);
    return (v >= NREQ) ? v - NREQ : v;
  endfunction

  // Search from the pointer upward, first requester found wins
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[wrap(int'(ptr_q) + i)]) begin
        found                        = 1'b1;
        gnt[wrap(int'(ptr_q) + i)]   = 1'b1;
        idx                          = IW'(wrap(int'(ptr_q) + i));
      end
    end
  end

  // Next search starts just after the accepted winner
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = IW'(wrap(int'(idx) + 1));
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dff_pc_arbiter.sv
// rtl/dff_pc_arbiter.sv - shares a preset/clear DFF bank among requesters; DFF_PC_ARB_CHECK_EN adds readback check
module dff_pc_arbiter
  import dff_pc_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy,
  output logic                  err,
  output logic [WIDTH-1:0]      reg_d,
  output logic [WIDTH-1:0]      reg_p,
  output logic [WIDTH-1:0]      reg_c,
  input  logic [WIDTH-1:0]      reg_q
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  op_e               op_q, op_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic [WIDTH-1:0]  reg_p_q, reg_p_d;
  logic [WIDTH-1:0]  reg_c_q, reg_c_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  op_e               win_op;
  logic [WIDTH-1:0]  win_wdata;

  assign accept    = (state_q == ST_IDLE) && (|req);
  assign win_op    = op_e'(op[2*int'(idx_q) +: 2]);
  assign win_wdata = wdata[WIDTH*int'(idx_q) +: WIDTH];

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .accept (accept),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave IDLE on any request, then walk the fixed sequence
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (|req) state_d = ST_GRANT;
    end else if (is_last_state(state_q)) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_GRANT || state_q == ST_APPLY || state_q == ST_SETTLE) begin
      state_d = state_e'(state_q + 3'd1);
    end else begin
      state_d = ST_IDLE;
    end
  end

  // FSM outputs: next values of the registered outputs and the latched operation
  always_comb begin
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    reg_p_d = '0;
    reg_c_d = '0;
    done_d  = '0;
    rdata_d = rdata_q;
    busy_d  = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gnt_d = arb_gnt;
          idx_d = arb_idx;
        end
      end
      ST_GRANT: begin
        // Latch the winner's request; P/C are prepared now so they are live during APPLY
        op_d    = win_op;
        wdata_d = win_wdata;
        if (win_op == OP_SET)   reg_p_d = win_wdata;
        if (win_op == OP_CLEAR) reg_c_d = win_wdata;
      end
      ST_SETTLE: begin
        done_d  = gnt_q;
        rdata_d = reg_q;
      end
      ST_DONE: begin
        gnt_d = '0;
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers; reset drops P/C at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= OP_READ;
      wdata_q <= '0;
      reg_p_q <= '0;
      reg_c_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      reg_p_q <= reg_p_d;
      reg_c_q <= reg_c_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  // Bank d input recirculates Q except while a LOAD is being applied
  always_comb begin
    reg_d = reg_q;
    if (state_q == ST_APPLY && op_q == OP_LOAD) begin
      reg_d = wdata_q;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign reg_p = reg_p_q;
  assign reg_c = reg_c_q;

`ifdef DFF_PC_ARB_CHECK_EN
  logic err_q, err_d;
  logic mismatch;

  // Compare the settled bank against what the latched op should have produced
  always_comb begin
    mismatch = 1'b0;
    case (op_q)
      OP_LOAD:  mismatch = (reg_q != wdata_q);
      OP_SET:   mismatch = ((reg_q & wdata_q) != wdata_q);
      OP_CLEAR: mismatch = ((reg_q & wdata_q) != '0);
      default:  mismatch = 1'b0;
    endcase
    err_d = err_q | ((state_q == ST_DONE) && mismatch);
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
